// File: rtl/aidan_mcnay_iter_divider_if.sv
// Divide stream interface between a requester (master) and the iterative
// divider (slave).
//   istream_*  : operand pair request, val/rdy handshake (master -> slave)
//   ostream_*  : quotient/remainder response, val/rdy handshake (slave -> master)
interface aidan_mcnay_iter_divider_if #(
  parameter int unsigned nbits = 16
);
  logic             istream_val;
  logic             istream_rdy;
  logic [nbits-1:0] istream_dividend;
  logic [nbits-1:0] istream_divisor;
  logic             ostream_val;
  logic             ostream_rdy;
  logic [nbits-1:0] ostream_quotient;
  logic [nbits-1:0] ostream_remainder;

  modport master (
    output istream_val, istream_dividend, istream_divisor, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_quotient, ostream_remainder
  );

  modport slave (
    input  istream_val, istream_dividend, istream_divisor, ostream_rdy,
    output istream_rdy, ostream_val, ostream_quotient, ostream_remainder
  );
endinterface

// File: rtl/aidan_mcnay_iter_divider.sv
// Iterative restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clk   : clock, all state updates on posedge
//   reset : synchronous, active-high reset
//   io    : divide stream interface (slave side)
//           istream_val/rdy + dividend/divisor in, ostream_val/rdy +
//           quotient/remainder out.
// A request accepted in cycle t produces ostream_val in cycle t+nbits+1.
// Divisor zero needs no special path: every trial subtraction succeeds, giving
// quotient all ones and remainder equal to the dividend.
module aidan_mcnay_iter_divider #(
  parameter int unsigned nbits = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  aidan_mcnay_iter_divider_if.slave   io
);

  localparam int unsigned CW = $clog2(nbits + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [nbits-1:0] quo, quo_next;
  logic [nbits-1:0] dvs, dvs_next;
  // The partial remainder is always below the divisor after a restore step,
  // so its (nbits+1)-th bit is always zero and is only materialised in the
  // shifted/trial values rather than stored.
  logic [nbits-1:0] rem, rem_next;
  logic [nbits:0]   shifted;
  logic [nbits:0]   trial;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
    end else begin
      cnt <= cnt_next;
      quo <= quo_next;
      rem <= rem_next;
      dvs <= dvs_next;
    end
  end

  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    quo_next       = quo;
    rem_next       = rem;
    dvs_next       = dvs;
    io.istream_rdy = 1'b0;
    io.ostream_val = 1'b0;

    // {rem, quo} shifted left by one; the bit leaving quo enters rem.
    shifted = {rem, quo[nbits-1]};
    trial   = shifted - {1'b0, dvs};

    case (state)
      IDLE: begin
        io.istream_rdy = 1'b1;
        if (io.istream_val) begin
          quo_next   = io.istream_dividend;
          dvs_next   = io.istream_divisor;
          rem_next   = '0;
          cnt_next   = CW'(nbits);
          state_next = CALC;
        end
      end
      CALC: begin
        cnt_next = cnt - CW'(1);
        if (trial[nbits]) begin
          rem_next = shifted[nbits-1:0];
          quo_next = {quo[nbits-2:0], 1'b0};
        end else begin
          rem_next = trial[nbits-1:0];
          quo_next = {quo[nbits-2:0], 1'b1};
        end
        if (cnt == CW'(1)) state_next = DONE;
      end
      DONE: begin
        io.ostream_val = 1'b1;
        if (io.ostream_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (reset) begin
      io.istream_rdy = 1'b0;
      io.ostream_val = 1'b0;
    end
  end

  assign io.ostream_quotient  = quo;
  assign io.ostream_remainder = rem;

endmodule

// File: tb/tb_aidan_mcnay_iter_divider.sv
module tb_aidan_mcnay_iter_divider;

  localparam int unsigned NB = 16;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  aidan_mcnay_iter_divider_if #(.nbits(NB)) dif ();

  aidan_mcnay_iter_divider #(.nbits(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain arithmetic, divisor zero gives all-ones / dividend.
  function automatic logic [31:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'd0) return {16'hFFFF, a};
    return {a / b, a % b};
  endfunction

  // Presents a request until it is taken (caller sits #1 after an edge).
  task automatic send_req(input logic [15:0] a, input logic [15:0] b,
                          input int bound, output bit ok);
    int  n;
    bit  took;
    n    = 0;
    took = 1'b0;
    dif.istream_dividend = a;
    dif.istream_divisor  = b;
    dif.istream_val      = 1'b1;
    while (!took && n < bound) begin
      took = dif.istream_rdy;
      @(posedge clk); #1;
      n++;
    end
    dif.istream_val = 1'b0;
    ok = took;
  endtask

  // Counts cycles from the handshake cycle to the first ostream_val.
  task automatic wait_result(output int lat, output bit ok);
    lat = 1;
    while (!dif.ostream_val && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = dif.ostream_val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if (dif.istream_rdy !== 1'b0 || dif.ostream_val !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b val=%b required rdy=0 val=0", dif.istream_rdy, dif.ostream_val);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dif.istream_rdy !== 1'b1 || dif.ostream_val !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: rdy=%b val=%b required rdy=1 val=0", dif.istream_rdy, dif.ostream_val);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int lat;
    dif.ostream_rdy = 1'b1;
    send_req(16'd17, 16'd5, 10, ok);
    wait_result(lat, ok);
    checks++;
    if (!ok || lat != 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d (val=%b) required 17", lat, ok);
    end
    checks++;
    if (dif.ostream_quotient !== 16'd3 || dif.ostream_remainder !== 16'd2) begin
      errors++;
      $display("FAIL basic_result: q=%0d r=%0d required q=3 r=2", dif.ostream_quotient, dif.ostream_remainder);
    end
    @(posedge clk); #1;
    checks++;
    if (dif.istream_rdy !== 1'b1 || dif.ostream_val !== 1'b0) begin
      errors++;
      $display("FAIL basic_back_to_idle: rdy=%b val=%b required rdy=1 val=0", dif.istream_rdy, dif.ostream_val);
    end
  endtask

  task automatic test_edge_operands();
    logic [15:0] ta [4] = '{16'd91, 16'd65535, 16'd3, 16'd65535};
    logic [15:0] tb [4] = '{16'd7,  16'd1,     16'd9, 16'd65535};
    logic [15:0] tq [4] = '{16'd13, 16'd65535, 16'd0, 16'd1};
    logic [15:0] tr [4] = '{16'd0,  16'd0,     16'd3, 16'd0};
    bit ok;
    int lat;
    dif.ostream_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_req(ta[i], tb[i], 10, ok);
      wait_result(lat, ok);
      checks++;
      if (!ok || dif.ostream_quotient !== tq[i] || dif.ostream_remainder !== tr[i]) begin
        errors++;
        $display("FAIL edge_%0d: %0d/%0d gave q=%0d r=%0d val=%b required q=%0d r=%0d",
                 i, ta[i], tb[i], dif.ostream_quotient, dif.ostream_remainder, ok, tq[i], tr[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_div_zero();
    bit ok;
    int lat;
    dif.ostream_rdy = 1'b1;
    send_req(16'd1234, 16'd0, 10, ok);
    wait_result(lat, ok);
    checks++;
    if (!ok || lat != 17) begin
      errors++;
      $display("FAIL divzero_latency: got %0d (val=%b) required 17", lat, ok);
    end
    checks++;
    if (dif.ostream_quotient !== 16'hFFFF || dif.ostream_remainder !== 16'd1234) begin
      errors++;
      $display("FAIL divzero_result: q=%h r=%0d required q=ffff r=1234", dif.ostream_quotient, dif.ostream_remainder);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    bit          ok;
    int          lat;
    logic [15:0] hq, hr;
    dif.ostream_rdy = 1'b0;
    send_req(16'd200, 16'd7, 10, ok);
    wait_result(lat, ok);
    hq = dif.ostream_quotient;
    hr = dif.ostream_remainder;
    checks++;
    if (!ok || hq !== 16'd28 || hr !== 16'd4) begin
      errors++;
      $display("FAIL bp_result: q=%0d r=%0d val=%b required q=28 r=4", hq, hr, ok);
    end
    // Offer a new request while the result is stalled; it must be ignored.
    dif.istream_dividend = 16'd50;
    dif.istream_divisor  = 16'd6;
    dif.istream_val      = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (dif.ostream_val !== 1'b1 || dif.istream_rdy !== 1'b0 ||
          dif.ostream_quotient !== hq || dif.ostream_remainder !== hr) begin
        errors++;
        $display("FAIL bp_hold_%0d: val=%b rdy=%b q=%0d r=%0d required val=1 rdy=0 q=%0d r=%0d",
                 c, dif.ostream_val, dif.istream_rdy, dif.ostream_quotient, dif.ostream_remainder, hq, hr);
      end
      @(posedge clk); #1;
    end
    // Sixth DONE cycle: accept the result.
    dif.ostream_rdy = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dif.istream_rdy !== 1'b1 || dif.ostream_val !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: rdy=%b val=%b required rdy=1 val=0", dif.istream_rdy, dif.ostream_val);
    end
    @(posedge clk); #1;
    dif.istream_val = 1'b0;
    wait_result(lat, ok);
    checks++;
    if (!ok || lat != 17 || dif.ostream_quotient !== 16'd8 || dif.ostream_remainder !== 16'd2) begin
      errors++;
      $display("FAIL bp_next_req: lat=%0d q=%0d r=%0d val=%b required lat=17 q=8 r=2",
               lat, dif.ostream_quotient, dif.ostream_remainder, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_calc();
    bit ok;
    bit seen;
    int lat;
    dif.ostream_rdy = 1'b1;
    send_req(16'd100, 16'd3, 10, ok);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dif.istream_rdy !== 1'b0 || dif.ostream_val !== 1'b0) begin
      errors++;
      $display("FAIL midreset_during: rdy=%b val=%b required rdy=0 val=0", dif.istream_rdy, dif.ostream_val);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dif.istream_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_rdy: rdy=%b required 1", dif.istream_rdy);
    end
    seen = 1'b0;
    repeat (25) begin
      if (dif.ostream_val === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_aborted: ostream_val rose=%b required 0", seen);
    end
    send_req(16'd100, 16'd3, 10, ok);
    wait_result(lat, ok);
    checks++;
    if (!ok || dif.ostream_quotient !== 16'd33 || dif.ostream_remainder !== 16'd1) begin
      errors++;
      $display("FAIL midreset_resubmit: q=%0d r=%0d val=%b required q=33 r=1",
               dif.ostream_quotient, dif.ostream_remainder, ok);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] expq[$];
    int          got;
    got = 0;
    fork
      begin : producer
        for (int i = 0; i < 200; i++) begin
          logic [15:0] a, b;
          bit          ok;
          a = 16'($urandom);
          case ($urandom_range(0, 3))
            0:       b = 16'($urandom_range(0, 3));
            1:       b = 16'($urandom_range(1, 255));
            default: b = 16'($urandom);
          endcase
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          send_req(a, b, 2000, ok);
          if (!ok) break;
          expq.push_back(ref_div(a, b));
        end
      end
      begin : consumer
        int          cyc;
        logic        v;
        logic [31:0] obs, exp_v;
        cyc = 0;
        while (got < 200 && cyc < 30000) begin
          dif.ostream_rdy = ($urandom_range(0, 9) < 7);
          v   = dif.ostream_val;
          obs = {dif.ostream_quotient, dif.ostream_remainder};
          @(posedge clk); #1;
          cyc++;
          if (v && dif.ostream_rdy) begin
            checks++;
            if (expq.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra: result q=%0d r=%0d with no outstanding request", obs[31:16], obs[15:0]);
            end else begin
              exp_v = expq.pop_front();
              if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b_%0d: q=%0d r=%0d required q=%0d r=%0d",
                         got, obs[31:16], obs[15:0], exp_v[31:16], exp_v[15:0]);
              end
            end
            got++;
          end
        end
      end
    join
    checks++;
    if (got != 200 || expq.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: received %0d outstanding %0d required 200 and 0", got, expq.size());
    end
  endtask

  initial begin
    reset                = 1'b1;
    dif.istream_val      = 1'b0;
    dif.istream_dividend = '0;
    dif.istream_divisor  = '0;
    dif.ostream_rdy      = 1'b0;
    test_reset();
    test_basic();
    test_edge_operands();
    test_div_zero();
    test_backpressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aidan_mcnay_iter_divider.md
Name: aidan_mcnay_iter_divider

Overview:
- Iterative restoring unsigned divider.
- Responder side of the divide stream protocol that the prime-detector control FSM initiates.
- Accepts a dividend/divisor pair over a val/rdy input stream, computes one quotient bit per cycle, and returns quotient and remainder over a val/rdy output stream.
- The prime detector uses the remainder (zero means clean division); the quotient is provided for reuse.

Parameters:
- nbits, 16, operand/result width in bits (supported range ≥2).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- istream_val  input  1  requester has a valid operand pair.
- istream_rdy  output  1  divider can accept an operand pair.
- istream_dividend  input  nbits  unsigned dividend.
- istream_divisor  input  nbits  unsigned divisor.
- ostream_val  output  1  result valid.
- ostream_rdy  input  1  requester accepts the result.
- ostream_quotient  output  nbits  unsigned quotient.
- ostream_remainder  output  nbits  unsigned remainder.

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Reset
  - Next state is IDLE.
  - Counter, quotient, remainder and divisor registers clear to 0.
  - While reset is high, istream_rdy=0 and ostream_val=0, regardless of state.
- States: IDLE, CALC, DONE (2-bit encoding).
  - No other state is reachable.
  - Any unused encoding returns to IDLE on the next edge.
- IDLE
  - istream_rdy=1, ostream_val=0.
  - On istream_val&istream_rdy: latch dividend into the quotient shift register, latch divisor, clear the (nbits+1)-bit partial remainder, load counter=nbits, go to CALC.
  - Otherwise stay in IDLE.
- CALC
  - istream_rdy=0, ostream_val=0.
  - Each cycle performs one restoring step:
    - Shift {rem, quo} left by 1.
    - trial = rem − {0,divisor}, computed (nbits+1) bits wide.
    - If trial is non-negative (MSB=0): rem=trial, quotient LSB=1.
    - Else: rem is unchanged, quotient LSB=0.
  - Counter decrements each cycle; on the step where the counter is 1, go to DONE.
  - Exactly nbits CALC cycles; no early termination.
- DONE
  - ostream_val=1.
  - ostream_quotient = quo register; ostream_remainder = rem[nbits-1:0].
  - Outputs are held stable while ostream_val=1 and ostream_rdy=0.
  - On ostream_rdy: go to IDLE.
  - istream_rdy=0 in DONE, so a new request is accepted no earlier than the cycle after the result transfer.
- Latency
  - Request handshake in cycle t → ostream_val first high in cycle t+nbits+1 (cycle t+17 for nbits=16).
  - Minimum initiation interval: nbits+2 cycles.
- Divisor zero
  - No special path; the restoring algorithm naturally yields quotient=all ones and remainder=dividend.
  - Same latency as any other request.
- Dividend < divisor
  - Quotient=0, remainder=dividend.
- Operand stability
  - Operands are sampled only at the handshake edge.
  - Input changes during CALC/DONE have no effect.
- Reset mid-operation (CALC or DONE)
  - Aborts the operation; the pending result is discarded and never presented.
  - IDLE on the next edge; istream_rdy=1 in the first cycle after reset deasserts.
- ostream_rdy high while not in DONE is ignored.
- istream_val high while not in IDLE is ignored.
- ostream_quotient and ostream_remainder are don't-care when ostream_val=0; the bench must not check them then.

Test Plan:
- Basic divide: reset 2 cycles, then 17/5 with ostream_rdy=1 → ostream_val high exactly 17 cycles after the handshake; q=3, r=2; IDLE with istream_rdy=1 the next cycle.
- Clean division and edge operands: 91/7 → q=13, r=0; 65535/1 → q=65535, r=0; 3/9 → q=0, r=3; 65535/65535 → q=1, r=0.
- Divide by zero: 1234/0 → q=0xFFFF, r=1234, same 17-cycle latency.
- Backpressure: hold ostream_rdy=0 for 5 cycles in DONE → ostream_val stays 1, outputs unchanged, istream_rdy=0 despite istream_val=1; transfer on the 6th cycle; a new request is accepted the following cycle.
- Reset mid-CALC: assert reset 6 cycles after accepting 100/3 → ostream_val never rises for that request; istream_rdy=1 after reset; 100/3 resubmitted → q=33, r=1.
- Back-to-back randomized: 200 random pairs with random istream_val/ostream_rdy gaps, checked against a reference model → every result matches, in order, with no drops or duplicates.
